// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one transaction at a time on a valid/ready data bus
// with an rvalid read response. It stalls upstream while busy and drives the MEM->WB registers.
module mem_access_unit #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             regwrite_mem,
   input  logic             memtoreg_mem,
   input  logic             memwrite_mem,
   input  logic [WIDTH-1:0] aluout_mem,
   input  logic [WIDTH-1:0] writedata_mem,
   input  logic [4:0]       regaddr_mem,
   output logic             stall_mem,
   output logic             bus_valid,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_ready,
   input  logic             bus_rvalid,
   input  logic [WIDTH-1:0] bus_rdata,
   output logic             regwrite_wb,
   output logic             memtoreg_wb,
   output logic [WIDTH-1:0] readdata_wb,
   output logic [WIDTH-1:0] aluout_wb,
   output logic [4:0]       regaddr_wb,
   output logic             err_mem
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_RDATA = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rbuf_q, rbuf_d;
   logic             err_q, err_d;
   logic             bus_valid_q, bus_valid_d;
   logic             bus_we_q, bus_we_d;
   logic [WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic             regwrite_wb_q, regwrite_wb_d;
   logic             memtoreg_wb_q, memtoreg_wb_d;
   logic [WIDTH-1:0] readdata_wb_q, readdata_wb_d;
   logic [WIDTH-1:0] aluout_wb_q, aluout_wb_d;
   logic [4:0]       regaddr_wb_q, regaddr_wb_d;

   logic memop, is_load, misaligned, timeout_hit, stall;

   // Store wins when both memtoreg and memwrite are set.
   assign memop       = memtoreg_mem | memwrite_mem;
   assign is_load     = memtoreg_mem & ~memwrite_mem;
   assign misaligned  = |aluout_mem[1:0];
   assign timeout_hit = (cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rbuf_d        = rbuf_q;
      err_d         = err_q;
      bus_valid_d   = bus_valid_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      regwrite_wb_d = regwrite_wb_q;
      memtoreg_wb_d = memtoreg_wb_q;
      readdata_wb_d = readdata_wb_q;
      aluout_wb_d   = aluout_wb_q;
      regaddr_wb_d  = regaddr_wb_q;
      stall         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (memop) begin
               stall = 1'b1;
               if (misaligned) begin
                  err_d   = 1'b1;
                  rbuf_d  = '0;
                  state_d = S_DONE;
               end else begin
                  bus_valid_d = 1'b1;
                  bus_we_d    = memwrite_mem;
                  bus_addr_d  = aluout_mem;
                  bus_wdata_d = writedata_mem;
                  cnt_d       = '0;
                  state_d     = S_REQ;
               end
            end
         end
         S_REQ: begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            // Timeout takes priority: the wait window is never longer than TIMEOUT cycles.
            if (timeout_hit) begin
               bus_valid_d = 1'b0;
               err_d       = 1'b1;
               rbuf_d      = '0;
               state_d     = S_DONE;
            end else if (bus_ready) begin
               bus_valid_d = 1'b0;
               state_d     = bus_we_q ? S_DONE : S_RDATA;
            end
         end
         S_RDATA: begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_hit) begin
               err_d   = 1'b1;
               rbuf_d  = '0;
               state_d = S_DONE;
            end else if (bus_rvalid) begin
               rbuf_d  = bus_rdata;
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A stalled cycle sends a bubble to WB; the other WB fields keep their value.
      if (stall) begin
         regwrite_wb_d = 1'b0;
      end else begin
         regwrite_wb_d = regwrite_mem;
         memtoreg_wb_d = memtoreg_mem;
         aluout_wb_d   = aluout_mem;
         regaddr_wb_d  = regaddr_mem;
         readdata_wb_d = is_load ? rbuf_q : '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         rbuf_q        <= '0;
         err_q         <= 1'b0;
         bus_valid_q   <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         regwrite_wb_q <= 1'b0;
         memtoreg_wb_q <= 1'b0;
         readdata_wb_q <= '0;
         aluout_wb_q   <= '0;
         regaddr_wb_q  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rbuf_q        <= rbuf_d;
         err_q         <= err_d;
         bus_valid_q   <= bus_valid_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         regwrite_wb_q <= regwrite_wb_d;
         memtoreg_wb_q <= memtoreg_wb_d;
         readdata_wb_q <= readdata_wb_d;
         aluout_wb_q   <= aluout_wb_d;
         regaddr_wb_q  <= regaddr_wb_d;
      end
   end

   assign stall_mem   = stall;
   assign bus_valid   = bus_valid_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wdata   = bus_wdata_q;
   assign regwrite_wb = regwrite_wb_q;
   assign memtoreg_wb = memtoreg_wb_q;
   assign readdata_wb = readdata_wb_q;
   assign aluout_wb   = aluout_wb_q;
   assign regaddr_wb  = regaddr_wb_q;
   assign err_mem     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a bus responder with programmable ready/rvalid delays, and a
// transaction-level model that predicts stall count, WB contents and the sticky error flag.
module tb_mem_access_unit;

   localparam int W  = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          regwrite_mem, memtoreg_mem, memwrite_mem;
   logic [W-1:0]  aluout_mem, writedata_mem;
   logic [4:0]    regaddr_mem;
   logic          stall_mem;
   logic          bus_valid, bus_we;
   logic [W-1:0]  bus_addr, bus_wdata;
   logic          bus_ready, bus_rvalid;
   logic [W-1:0]  bus_rdata;
   logic          regwrite_wb, memtoreg_wb;
   logic [W-1:0]  readdata_wb, aluout_wb;
   logic [4:0]    regaddr_wb;
   logic          err_mem;

   int   checks = 0;
   int   errors = 0;
   logic exp_err = 1'b0;

   mem_access_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
      .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .regaddr_mem(regaddr_mem),
      .stall_mem(stall_mem),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb), .readdata_wb(readdata_wb),
      .aluout_wb(aluout_wb), .regaddr_wb(regaddr_wb), .err_mem(err_mem)
   );

   always #5 clk = ~clk;

   // Runs one instruction starting just after a negedge and ends just after a later negedge,
   // once its result is visible on the WB outputs. rdy_dly = REQ cycles with ready low,
   // rv_dly = RDATA cycles with rvalid low before the data beat.
   task automatic run_op(input logic rw, input logic mtr, input logic mw,
                         input logic [W-1:0] addr, input logic [W-1:0] wdata,
                         input logic [W-1:0] rdata, input logic [4:0] ra,
                         input int rdy_dly, input int rv_dly, input string name);
      logic         memop, load, mis, timed, seen, accepted, acc_now, done;
      int           wait_c, exp_stall, stalls, vcnt, rcnt;
      logic [W-1:0] exp_rd;
      memop  = mtr | mw;
      load   = mtr & ~mw;
      mis    = memop && (addr[1:0] != 2'b00);
      wait_c = mw ? rdy_dly + 1 : rdy_dly + 1 + rv_dly + 1;
      timed  = memop && !mis && (wait_c >= TO);
      if (!memop)     exp_stall = 0;
      else if (mis)   exp_stall = 1;
      else if (timed) exp_stall = 1 + TO;
      else            exp_stall = 1 + wait_c;
      if (mis || timed) exp_err = 1'b1;
      exp_rd = (load && !mis && !timed) ? rdata : '0;

      regwrite_mem = rw; memtoreg_mem = mtr; memwrite_mem = mw;
      aluout_mem = addr; writedata_mem = wdata; regaddr_mem = ra;
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      seen = 0; accepted = 0; stalls = 0; vcnt = 0; rcnt = 0; done = 0;

      for (int cyc = 0; cyc < 60; cyc++) begin
         #1;
         acc_now = 0;
         if (bus_valid) begin
            seen = 1;
            checks++;
            if (accepted || bus_addr !== addr || bus_wdata !== wdata || bus_we !== mw) begin
               errors++;
               $display("FAIL %s bus_hold: valid=1 addr=%h wdata=%h we=%b accepted=%0d, required addr=%h wdata=%h we=%b and no valid after accept",
                        name, bus_addr, bus_wdata, bus_we, accepted, addr, wdata, mw);
            end
         end
         if (bus_valid && !accepted) begin
            bus_ready  = (vcnt >= rdy_dly);
            vcnt++;
            bus_rvalid = 1'b1;       // stray response during REQ must be ignored
            bus_rdata  = ~rdata;
            acc_now    = bus_ready;
         end else if (accepted && load) begin
            bus_ready  = 1'b0;
            bus_rvalid = (rcnt == rv_dly);
            bus_rdata  = rdata;
            rcnt++;
         end else begin
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
         end
         if (!stall_mem) begin
            done = 1;
            break;
         end
         stalls++;
         @(negedge clk);
         if (acc_now) accepted = 1;
         checks++;
         if (regwrite_wb !== 1'b0) begin
            errors++;
            $display("FAIL %s bubble: regwrite_wb=%b required 0", name, regwrite_wb);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s completion: stall_mem still high after 60 cycles, required release", name);
      end
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);

      checks++;
      if (stalls != exp_stall) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d required %0d", name, stalls, exp_stall);
      end
      checks++;
      if (seen != (memop && !mis)) begin
         errors++;
         $display("FAIL %s bus_request: saw_valid=%0d required %0d", name, seen, memop && !mis);
      end
      checks++;
      if (regwrite_wb !== rw || memtoreg_wb !== mtr || aluout_wb !== addr || regaddr_wb !== ra) begin
         errors++;
         $display("FAIL %s wb_fields: rw=%b mtr=%b alu=%h ra=%0d required rw=%b mtr=%b alu=%h ra=%0d",
                  name, regwrite_wb, memtoreg_wb, aluout_wb, regaddr_wb, rw, mtr, addr, ra);
      end
      checks++;
      if (readdata_wb !== exp_rd) begin
         errors++;
         $display("FAIL %s readdata_wb: got %h required %h", name, readdata_wb, exp_rd);
      end
      checks++;
      if (err_mem !== exp_err) begin
         errors++;
         $display("FAIL %s err_mem: got %b required %b", name, err_mem, exp_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      regwrite_mem = 0; memtoreg_mem = 0; memwrite_mem = 0;
      aluout_mem = '0; writedata_mem = '0; regaddr_mem = '0;
      bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus_valid !== 1'b0 || regwrite_wb !== 1'b0 || memtoreg_wb !== 1'b0 || readdata_wb !== '0 ||
          aluout_wb !== '0 || regaddr_wb !== '0 || err_mem !== 1'b0 || stall_mem !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b rw=%b mtr=%b rd=%h alu=%h ra=%0d err=%b stall=%b required all 0",
                  bus_valid, regwrite_wb, memtoreg_wb, readdata_wb, aluout_wb, regaddr_wb, err_mem, stall_mem);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu();
      run_op(1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 5'd5, 0, 0, "alu");
   endtask

   task automatic test_misaligned();
      run_op(1, 1, 0, 32'h0000_0203, 32'h0, 32'hCAFE_F00D, 5'd7, 0, 0, "misaligned_load");
   endtask

   task automatic test_reset_mid_req();
      regwrite_mem = 0; memtoreg_mem = 0; memwrite_mem = 1;
      aluout_mem = 32'h40; writedata_mem = 32'hA5A5_0001; regaddr_mem = 5'd3;
      bus_ready = 0; bus_rvalid = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (bus_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_req precondition: bus_valid=%b required 1", bus_valid);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (bus_valid !== 1'b0 || regwrite_wb !== 1'b0 || memtoreg_wb !== 1'b0 || readdata_wb !== '0 ||
          aluout_wb !== '0 || regaddr_wb !== '0 || err_mem !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_req outputs: valid=%b rw=%b mtr=%b rd=%h alu=%h ra=%0d err=%b required all 0",
                  bus_valid, regwrite_wb, memtoreg_wb, readdata_wb, aluout_wb, regaddr_wb, err_mem);
      end
      exp_err = 1'b0;
      memwrite_mem = 0; aluout_mem = '0; writedata_mem = '0;
      @(negedge clk);
      rst = 1'b1;
      run_op(0, 0, 1, 32'h0000_0044, 32'h1111_2222, 32'h0, 5'd0, 0, 0, "store_after_reset");
   endtask

   task automatic test_store();
      run_op(0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5'd0, 2, 0, "store_ready_late");
   endtask

   task automatic test_load();
      run_op(1, 1, 0, 32'h0000_0200, 32'h0, 32'h1234_5678, 5'd9, 0, 1, "load");
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         int           kind;
         logic [W-1:0] a;
         kind = int'($urandom_range(0, 3));
         a    = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         run_op(1'($urandom), kind == 1 || kind == 3, kind >= 2, a, $urandom, $urandom,
                5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "random");
      end
   endtask

   task automatic test_timeout();
      run_op(1, 1, 0, 32'h0000_0300, 32'h0, 32'h7777_7777, 5'd4, 0, 1000, "load_timeout");
      run_op(0, 0, 1, 32'h0000_0304, 32'h0BAD_F00D, 32'h0, 5'd0, 1, 0, "store_after_timeout");
      run_op(0, 0, 1, 32'h0000_0308, 32'h5555_AAAA, 32'h0, 5'd0, 500, 0, "store_timeout");
   endtask

   task automatic test_back_to_back();
      run_op(0, 0, 1, 32'h0000_0400, 32'h0102_0304, 32'h0, 5'd1, 0, 0, "b2b_store");
      run_op(1, 1, 0, 32'h0000_0404, 32'h0, 32'h89AB_CDEF, 5'd2, 0, 0, "b2b_load");
      run_op(1, 1, 0, 32'h0000_0408, 32'h0, 32'h0F0F_F0F0, 5'd3, 1, 2, "b2b_load2");
      run_op(1, 1, 1, 32'h0000_040C, 32'h3333_4444, 32'h9999_9999, 5'd6, 0, 0, "b2b_both_is_store");
      run_op(1, 0, 0, 32'h0000_0001, 32'h0, 32'h0, 5'd31, 0, 0, "b2b_alu");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_misaligned();
      test_reset_mid_req();
      test_store();
      test_load();
      test_back_to_back();
      test_random();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
